// File: rtl/ram_arbiter.sv
// Round-robin arbiter/sequencer that lets two req/ack masters share one
// single-port RAM; all RAM controls are registered so they never glitch.
module ram_arbiter #(
    parameter int unsigned READ_LAT = 1,
    parameter int unsigned AW       = 9,
    parameter int unsigned DW       = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          ack0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          ack1,
    output logic [DW-1:0] rdata1,
    output logic          busy,
    output logic          ram_WE,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_in,
    input  logic [DW-1:0] ram_out
);

    localparam int unsigned CW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        ACK    = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic          gnt_id_q, gnt_id_d;
    logic          op_we_q, op_we_d;
    logic          last_q, last_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic [DW-1:0] rdata0_q, rdata0_d;
    logic [DW-1:0] rdata1_q, rdata1_d;
    logic          ram_we_q, ram_we_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic [DW-1:0] ram_in_q, ram_in_d;

    logic          grant_id;
    logic          sel_we;

    // Tie goes to the requester that was not served last.
    always_comb begin
        grant_id = 1'b0;
        if (req0 && req1) begin
            grant_id = ~last_q;
        end else if (req1) begin
            grant_id = 1'b1;
        end
        sel_we = grant_id ? we1 : we0;
    end

    always_comb begin
        state_d    = state_q;
        gnt_id_d   = gnt_id_q;
        op_we_d    = op_we_q;
        last_d     = last_q;
        wait_cnt_d = wait_cnt_q;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;
        ram_we_d   = 1'b1;
        ram_addr_d = ram_addr_q;
        ram_in_d   = ram_in_q;

        unique case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    gnt_id_d   = grant_id;
                    op_we_d    = sel_we;
                    ram_addr_d = grant_id ? addr1 : addr0;
                    ram_in_d   = grant_id ? wdata1 : wdata0;
                    // WE is registered, so it is low exactly during ACCESS.
                    ram_we_d   = ~sel_we;
                    state_d    = ACCESS;
                end
            end
            ACCESS: begin
                wait_cnt_d = '0;
                state_d    = op_we_q ? ACK : WAIT;
            end
            WAIT: begin
                if (wait_cnt_q == CW'(READ_LAT - 1)) begin
                    if (gnt_id_q) begin
                        rdata1_d = ram_out;
                    end else begin
                        rdata0_d = ram_out;
                    end
                    state_d = ACK;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            ACK: begin
                last_d  = gnt_id_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_id_q   <= 1'b0;
            op_we_q    <= 1'b0;
            last_q     <= 1'b1;
            wait_cnt_q <= '0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
            ram_we_q   <= 1'b1;
            ram_addr_q <= '0;
            ram_in_q   <= '0;
        end else begin
            state_q    <= state_d;
            gnt_id_q   <= gnt_id_d;
            op_we_q    <= op_we_d;
            last_q     <= last_d;
            wait_cnt_q <= wait_cnt_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
            ram_we_q   <= ram_we_d;
            ram_addr_q <= ram_addr_d;
            ram_in_q   <= ram_in_d;
        end
    end

    assign ack0     = (state_q == ACK) && !gnt_id_q;
    assign ack1     = (state_q == ACK) && gnt_id_q;
    assign busy     = (state_q != IDLE);
    assign rdata0   = rdata0_q;
    assign rdata1   = rdata1_q;
    assign ram_WE   = ram_we_q;
    assign ram_addr = ram_addr_q;
    assign ram_in   = ram_in_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural 512x16 RAM of READ_LAT latency.
module tb_ram_arbiter;

    localparam int unsigned READ_LAT = 1;
    localparam int unsigned AW       = 9;
    localparam int unsigned DW       = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0, we0, req1, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          ack0, ack1, busy, ram_WE;
    logic [DW-1:0] rdata0, rdata1, ram_in, ram_out;
    logic [AW-1:0] ram_addr;

    int total = 0;
    int bad   = 0;
    int we_low_cnt = 0;

    ram_arbiter #(.READ_LAT(READ_LAT), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .ack0(ack0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .ack1(ack1), .rdata1(rdata1),
        .busy(busy), .ram_WE(ram_WE), .ram_addr(ram_addr),
        .ram_in(ram_in), .ram_out(ram_out)
    );

    always #5 clk = ~clk;

    // RAM model: address registered on the edge, data out READ_LAT cycles later.
    logic [DW-1:0] mem [512];
    logic [DW-1:0] rd_pipe [READ_LAT];
    always @(posedge clk) begin
        if (!ram_WE) mem[ram_addr] <= ram_in;
        rd_pipe[0] <= mem[ram_addr];
        for (int i = 1; i < int'(READ_LAT); i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign ram_out = rd_pipe[READ_LAT-1];

    always @(negedge clk) if (!ram_WE) we_low_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns the id of the first ack (2 = both, -1 = none) and cycles taken.
    task automatic wait_ack(output int id, output int cyc);
        id  = -1;
        cyc = 0;
        for (int i = 0; i < 40 && id < 0; i++) begin
            step();
            cyc++;
            if (ack0 && ack1) id = 2;
            else if (ack0)    id = 0;
            else if (ack1)    id = 1;
        end
    endtask

    task automatic txn(input logic who, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, output int id, output int cyc);
        if (who) begin
            req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d;
        end else begin
            req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d;
        end
        wait_ack(id, cyc);
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    initial begin
        int id, cyc, w0, seen;
        rst = 1'b1;
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
        repeat (2) step();
        check("rst_we", ram_WE, 1);
        check("rst_addr", ram_addr, 0);
        check("rst_in", ram_in, 0);
        check("rst_ack0", ack0, 0);
        check("rst_ack1", ack1, 0);
        check("rst_busy", busy, 0);
        check("rst_rdata0", rdata0, 0);
        rst = 1'b0;
        step();

        // Reset during WAIT of a read
        req0 = 1'b1; we0 = 1'b0; addr0 = 9'd7;
        step();
        check("abort_acc_addr", ram_addr, 7);
        check("abort_acc_we", ram_WE, 1);
        step();
        check("abort_wait_busy", busy, 1);
        rst = 1'b1; req0 = 1'b0;
        step();
        check("abort_busy", busy, 0);
        check("abort_addr", ram_addr, 0);
        check("abort_we", ram_WE, 1);
        check("abort_ack0", ack0, 0);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (ack0 || ack1) seen++;
        end
        check("abort_no_ack", seen, 0);

        // Single write from requester 0
        w0 = we_low_cnt;
        req0 = 1'b1; we0 = 1'b1; addr0 = 9'd3; wdata0 = 16'd40;
        step();
        check("wr_acc_we", ram_WE, 0);
        check("wr_acc_addr", ram_addr, 3);
        check("wr_acc_in", ram_in, 40);
        check("wr_acc_ack0", ack0, 0);
        step();
        check("wr_ack0", ack0, 1);
        check("wr_ack1", ack1, 0);
        check("wr_ack_we", ram_WE, 1);
        check("wr_ack_addr_hold", ram_addr, 3);
        req0 = 1'b0;
        step();
        check("wr_idle_ack0", ack0, 0);
        check("wr_idle_busy", busy, 0);
        check("wr_we_low_cycles", we_low_cnt - w0, 1);

        // Read it back
        txn(1'b0, 1'b0, 9'd3, 16'd0, id, cyc);
        check("rd_id", id, 0);
        check("rd_latency", cyc, 2 + READ_LAT);
        check("rd_data0", rdata0, 40);
        step();

        // Requester 1 read does not disturb requester 0
        txn(1'b1, 1'b1, 9'd2, 16'd30, id, cyc);
        check("iso_wr_id", id, 1);
        check("iso_wr_latency", cyc, 2);
        step();
        txn(1'b1, 1'b0, 9'd2, 16'd0, id, cyc);
        check("iso_rd_id", id, 1);
        check("iso_rdata1", rdata1, 30);
        check("iso_rdata0", rdata0, 40);
        step();

        // Simultaneous requests straight after reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        req0 = 1'b1; we0 = 1'b1; addr0 = 9'd0; wdata0 = 16'd10;
        req1 = 1'b1; we1 = 1'b1; addr1 = 9'd1; wdata1 = 16'd20;
        wait_ack(id, cyc);
        check("sim_first", id, 0);
        check("sim_first_lat", cyc, 2);
        req0 = 1'b0;
        wait_ack(id, cyc);
        check("sim_second", id, 1);
        check("sim_second_lat", cyc, 3);
        req1 = 1'b0;
        step();
        txn(1'b0, 1'b0, 9'd0, 16'd0, id, cyc);
        check("sim_rb0", rdata0, 10);
        step();
        txn(1'b1, 1'b0, 9'd1, 16'd0, id, cyc);
        check("sim_rb1", rdata1, 20);
        step();

        // Fairness: both held for six transactions; requester 1 was served last
        req0 = 1'b1; we0 = 1'b1; addr0 = 9'd0; wdata0 = 16'd10;
        req1 = 1'b1; we1 = 1'b1; addr1 = 9'd1; wdata1 = 16'd20;
        for (int k = 0; k < 6; k++) begin
            wait_ack(id, cyc);
            check($sformatf("fair_%0d", k), id, k % 2);
        end
        req0 = 1'b0; req1 = 1'b0;
        step();

        // Latching: inputs change and req drops after the grant
        req1 = 1'b1; we1 = 1'b1; addr1 = 9'd5; wdata1 = 16'd55;
        step();
        addr1 = 9'd6; wdata1 = 16'd66; we1 = 1'b0; req1 = 1'b0;
        check("lat_addr", ram_addr, 5);
        check("lat_in", ram_in, 55);
        check("lat_we", ram_WE, 0);
        wait_ack(id, cyc);
        check("lat_ack_id", id, 1);
        check("lat_ack_lat", cyc, 1);
        step();
        check("lat_ack_once", ack1, 0);
        txn(1'b0, 1'b0, 9'd5, 16'd0, id, cyc);
        check("lat_rb", rdata0, 55);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-requester round-robin arbiter and sequencer for the 512 x 16 single-port RAM (9-bit address, 16-bit data, WE low = write).
- It lets two masters share the RAM, for example the PC-driven fetch side and a load/store side.
- Each master uses a req/ack handshake; the block serialises their transactions onto the RAM port.
- It owns every RAM control signal (WE, addr, in) and captures read data from the RAM `out`.

## Interface
Parameters:
- READ_LAT, 1, cycles from the edge that registers a read address to the cycle in which RAM `out` is valid and sampled (1..4)
- AW, 9, address width
- DW, 16, data width

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- req0  in  1  requester 0 transaction request
- we0  in  1  requester 0 operation: 1 = write, 0 = read
- addr0  in  AW  requester 0 address
- wdata0  in  DW  requester 0 write data
- ack0  out  1  one-cycle completion pulse to requester 0
- rdata0  out  DW  requester 0 read data; valid when ack0=1, held until its next read completes
- req1, we1, addr1, wdata1, ack1, rdata1: identical signals for requester 1
- busy  out  1  high in every state except IDLE
- ram_WE  out  1  RAM write strobe, active low (0 = write, 1 = read/idle)
- ram_addr  out  AW  RAM address
- ram_in  out  DW  RAM write data
- ram_out  in  DW  RAM read data

## Operation
FSM states: IDLE, ACCESS, WAIT, ACK.

- **IDLE**
  - If no request is pending, stay in IDLE.
  - If only one req is high, grant that requester.
  - If both are high, grant the requester that is not `last`.
  - On a grant, latch the granted requester's id, we, addr and wdata into internal registers, then go to ACCESS.
- **ACCESS** (always 1 cycle)
  - Drive ram_addr and ram_in from the latched values.
  - ram_WE = 0 for a write, 1 for a read.
  - A write goes next to ACK. A read goes next to WAIT.
- **WAIT** (reads only, READ_LAT cycles)
  - ram_addr stays at the latched address and ram_WE = 1.
  - On the final WAIT cycle's edge, capture ram_out into rdata of the granted requester, then go to ACK.
- **ACK** (1 cycle)
  - Assert ack for the granted requester only.
  - Set `last` to the granted id, then go to IDLE.
- ram_WE is 0 only in ACCESS of a write, and never for more than one cycle per transaction.
- ram_addr and ram_in hold their last driven values in IDLE and ACK.
- Request values are latched at grant. Changes to addr, wdata or we after the grant have no effect on the current transaction.
- A requester deasserts req in the cycle after its ack. A req still high in that cycle is a new request.
- A req dropped before its ack does not abort the transaction; it still completes and acks.
- Reset values:
  - state = IDLE, busy = 0
  - ack0 = ack1 = 0
  - rdata0 = rdata1 = 0
  - ram_WE = 1, ram_addr = 0, ram_in = 0
  - last = 1, so requester 0 wins the first tie
- rst asserted in any state, including mid-transaction, forces the reset values on the next edge. No ack is issued for the aborted transaction. A write aborted in ACCESS may already have been committed by that edge.

## Timing
- Cycle 0 is the IDLE cycle in which req is sampled high.
- Write: ACCESS in cycle 1, with the RAM writing on the cycle-1 end edge. ack in cycle 2. Requests sampled in IDLE from cycle 3.
- Read: ACCESS in cycle 1, WAIT in cycles 2..1+READ_LAT, ack and valid rdata in cycle 2+READ_LAT.
- Back-to-back rate: one write per 3 cycles; one read per 3+READ_LAT cycles.
- Worst-case wait when both requesters are continuously requesting: one transaction of the other requester, because round-robin gives strict alternation.
- The ack of one requester never coincides with a grant in the same cycle.

## Test plan
- **Reset state:** apply rst for 2 cycles → ram_WE=1, ram_addr=0, ack0=ack1=0, busy=0. Then assert rst mid-WAIT of a read → no ack; outputs return to reset values next cycle.
- **Single write then read, requester 0:**
  - Write addr0=3, wdata0=16'd40 → ram_WE=0 for exactly 1 cycle with ram_addr=3 and ram_in=40; ack0 in cycle 2.
  - Read addr0=3 → rdata0=40 with ack0 in cycle 3 (READ_LAT=1).
- **Simultaneous requests after reset:**
  - req0 writes addr 0 = 10; req1 writes addr 1 = 20, both held → requester 0 is acked first, then requester 1.
  - Read both addresses back → 10 and 20.
- **Fairness:** hold req0 and req1 high for 6 transactions → ack order 0,1,0,1,0,1, with no requester served twice in a row.
- **Latching:** change addr1 and wdata1 one cycle after the grant → the RAM sees the originally latched values. Also drop req1 before ack → ack1 still pulses once.
- **Read data isolation:** requester 1 reads addr 2 = 30 while rdata0 holds 40 → rdata1=30, rdata0 stays 40, and ack0 stays 0.
